// File: rtl/cdb_arbiter_if.sv
// Result-bus bundle around cdb_arbiter: the two producer result ports with
// their accept back-pressure, plus the registered common data bus.
// The arbiter is the slave; producers and CDB consumers sit on the master side.
interface cdb_arbiter_if #(
    parameter int ROB_WIDTH = 4
);
    // RS / ALU result port
    logic                 rs_valid;
    logic [ROB_WIDTH-1:0] rs_rob_id;
    logic [31:0]          rs_value;
    logic                 rs_accept;

    // LSB load result port
    logic                 lsb_valid;
    logic [ROB_WIDTH-1:0] lsb_rob_id;
    logic [31:0]          lsb_value;
    logic                 lsb_accept;

    // Common data bus broadcast
    logic                 cdb_valid;
    logic [ROB_WIDTH-1:0] cdb_rob_id;
    logic [31:0]          cdb_value;
    logic                 cdb_src;

    modport master (
        output rs_valid, rs_rob_id, rs_value,
        input  rs_accept,
        output lsb_valid, lsb_rob_id, lsb_value,
        input  lsb_accept,
        input  cdb_valid, cdb_rob_id, cdb_value, cdb_src
    );

    modport slave (
        input  rs_valid, rs_rob_id, rs_value,
        output rs_accept,
        input  lsb_valid, lsb_rob_id, lsb_value,
        output lsb_accept,
        output cdb_valid, cdb_rob_id, cdb_value, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one skid FIFO per producer (RS, LSB), a
// round-robin grant of at most one result per cycle, and a registered CDB.
// An empty FIFO lets the incoming result bypass straight onto the bus.
module cdb_arbiter #(
    parameter int ROB_WIDTH  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         clear,
    cdb_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Source index 0 is the RS port, 1 is the LSB port; cdb_src uses the same coding.
    typedef enum logic {
        SRC_RS  = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

    // Per-source FIFO state
    logic [ROB_WIDTH-1:0] id_mem    [2][FIFO_DEPTH];
    logic [31:0]          value_mem [2][FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr    [2];
    logic [PTR_W-1:0]     wr_ptr    [2];
    logic [CNT_W-1:0]     count     [2];

    // Arbitration state and registered bus
    src_e                 last_grant;
    logic                 cdb_valid_q;
    logic [ROB_WIDTH-1:0] cdb_rob_id_q;
    logic [31:0]          cdb_value_q;
    src_e                 cdb_src_q;

    // Per-cycle decode
    logic [1:0]           accept;
    logic [1:0]           in_valid;
    logic [ROB_WIDTH-1:0] in_id     [2];
    logic [31:0]          in_value  [2];
    logic [1:0]           cand_valid;
    logic [ROB_WIDTH-1:0] cand_id   [2];
    logic [31:0]          cand_value[2];
    logic [1:0]           grant;
    src_e                 grant_src;
    logic [1:0]           push;
    logic [1:0]           pop;

    // Accept comes from the registered count only; a result offered while
    // the FIFO is full is a protocol violation and is simply dropped.
    always_comb begin
        in_id[0]    = bus.rs_rob_id;
        in_id[1]    = bus.lsb_rob_id;
        in_value[0] = bus.rs_value;
        in_value[1] = bus.lsb_value;
        for (int x = 0; x < 2; x++) begin
            accept[x] = (count[x] < CNT_W'(FIFO_DEPTH));
        end
        in_valid[0] = bus.rs_valid  & accept[0];
        in_valid[1] = bus.lsb_valid & accept[1];
    end

    // Candidate per source: FIFO head when buffered, else the incoming result.
    always_comb begin
        for (int x = 0; x < 2; x++) begin
            cand_valid[x] = (count[x] != '0) | in_valid[x];
            if (count[x] != '0) begin
                cand_id[x]    = id_mem[x][rd_ptr[x]];
                cand_value[x] = value_mem[x][rd_ptr[x]];
            end else begin
                cand_id[x]    = in_id[x];
                cand_value[x] = in_value[x];
            end
        end
    end

    // Round-robin grant and the resulting push/pop decisions.
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        grant = cand_valid;
        if (&cand_valid) begin
            grant = (last_grant == SRC_LSB) ? 2'b01 : 2'b10;
        end
        grant_src = src_e'(grant[1]);
        for (int x = 0; x < 2; x++) begin
            pop[x]  = grant[x] & (count[x] != '0);
            // A granted bypass goes straight to the bus and is never stored.
            push[x] = in_valid[x] & ~(grant[x] & (count[x] == '0));
        end
    end

    // Control state: pointers, counts, round-robin pointer and the CDB register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int x = 0; x < 2; x++) begin
                rd_ptr[x] <= '0;
                wr_ptr[x] <= '0;
                count[x]  <= '0;
            end
            last_grant   <= SRC_LSB;
            cdb_valid_q  <= 1'b0;
            cdb_rob_id_q <= '0;
            cdb_value_q  <= '0;
            cdb_src_q    <= SRC_RS;
        end else if (rdy_in) begin
            if (clear) begin
                for (int x = 0; x < 2; x++) begin
                    rd_ptr[x] <= '0;
                    wr_ptr[x] <= '0;
                    count[x]  <= '0;
                end
                last_grant  <= SRC_LSB;
                cdb_valid_q <= 1'b0;
            end else begin
                for (int x = 0; x < 2; x++) begin
                    if (push[x]) wr_ptr[x] <= wr_ptr[x] + 1'b1;
                    if (pop[x])  rd_ptr[x] <= rd_ptr[x] + 1'b1;
                    count[x] <= count[x] + CNT_W'(push[x]) - CNT_W'(pop[x]);
                end
                if (|grant) begin
                    cdb_valid_q  <= 1'b1;
                    cdb_rob_id_q <= cand_id[grant_src];
                    cdb_value_q  <= cand_value[grant_src];
                    cdb_src_q    <= grant_src;
                    last_grant   <= grant_src;
                end else begin
                    cdb_valid_q  <= 1'b0;
                end
            end
        end
    end

    // FIFO storage writes.
    // NOTE: the storage arrays are deliberately not reset; count and pointers alone decide which slots hold live data.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !clear) begin
            for (int x = 0; x < 2; x++) begin
                if (push[x]) begin
                    id_mem[x][wr_ptr[x]]    <= in_id[x];
                    value_mem[x][wr_ptr[x]] <= in_value[x];
                end
            end
        end
    end

    assign bus.rs_accept  = accept[0];
    assign bus.lsb_accept = accept[1];
    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_rob_id = cdb_rob_id_q;
    assign bus.cdb_value  = cdb_value_q;
    assign bus.cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a table of hand-derived vectors, hand sequences for
// asynchronous reset, and randomized traffic against a queue-based model.
module tb_cdb_arbiter;

    localparam int RW    = 4;
    localparam int DEPTH = 2;

    logic clk_in;
    logic rst_in;
    logic rdy_in;
    logic clear;

    cdb_arbiter_if #(.ROB_WIDTH(RW)) bus ();

    cdb_arbiter #(.ROB_WIDTH(RW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input bit ev, input logic [RW-1:0] eid,
                             input logic [31:0] evl, input bit esrc, input bit era, input bit ela);
        check({tag, ".cdb_valid"},  32'(bus.cdb_valid),  32'(ev));
        check({tag, ".cdb_rob_id"}, 32'(bus.cdb_rob_id), 32'(eid));
        check({tag, ".cdb_value"},  bus.cdb_value,       evl);
        check({tag, ".cdb_src"},    32'(bus.cdb_src),    32'(esrc));
        check({tag, ".rs_accept"},  32'(bus.rs_accept),  32'(era));
        check({tag, ".lsb_accept"}, 32'(bus.lsb_accept), 32'(ela));
    endtask

    task automatic drive(input bit rv, input logic [RW-1:0] rid, input logic [31:0] rval,
                         input bit lv, input logic [RW-1:0] lid, input logic [31:0] lval);
        bus.rs_valid   = rv;
        bus.rs_rob_id  = rid;
        bus.rs_value   = rval;
        bus.lsb_valid  = lv;
        bus.lsb_rob_id = lid;
        bus.lsb_value  = lval;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        bit              do_rst;
        bit              rdy;
        bit              clr;
        bit              rv;
        logic [RW-1:0]   rid;
        logic [31:0]     rval;
        bit              lv;
        logic [RW-1:0]   lid;
        logic [31:0]     lval;
        bit              ev;
        logic [RW-1:0]   eid;
        logic [31:0]     evl;
        bit              esrc;
        bit              era;
        bit              ela;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit do_rst, bit rdy, bit clr,
                                bit rv, logic [RW-1:0] rid, logic [31:0] rval,
                                bit lv, logic [RW-1:0] lid, logic [31:0] lval,
                                bit ev, logic [RW-1:0] eid, logic [31:0] evl,
                                bit esrc, bit era, bit ela);
        vec_t v;
        v.do_rst = do_rst; v.rdy = rdy; v.clr = clr;
        v.rv = rv; v.rid = rid; v.rval = rval;
        v.lv = lv; v.lid = lid; v.lval = lval;
        v.ev = ev; v.eid = eid; v.evl = evl; v.esrc = esrc;
        v.era = era; v.ela = ela;
        return v;
    endfunction

    task automatic pulse_reset();
        rst_in = 1'b1;
        #2;
        rst_in = 1'b0;
    endtask

    // Called away from the clock edge; drives one row, clocks once, compares.
    task automatic apply(input int idx, input vec_t v);
        if (v.do_rst) pulse_reset();
        rdy_in = v.rdy;
        clear  = v.clr;
        drive(v.rv, v.rid, v.rval, v.lv, v.lid, v.lval);
        @(posedge clk_in);
        #1;
        check_all($sformatf("row%0d", idx), v.ev, v.eid, v.evl, v.esrc, v.era, v.ela);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [RW-1:0] id;
        logic [31:0]   val;
    } ent_t;

    ent_t          mq_rs[$];
    ent_t          mq_lsb[$];
    bit            m_valid;
    logic [RW-1:0] m_id;
    logic [31:0]   m_val;
    bit            m_src;
    bit            m_last;

    task automatic model_reset();
        mq_rs.delete();
        mq_lsb.delete();
        m_valid = 0; m_id = '0; m_val = '0; m_src = 0; m_last = 1;
    endtask

    // Accepted results join their source queue; the bus then takes the oldest
    // result of the chosen source (a result that joined an empty queue and is
    // chosen at once is exactly the bypass case).
    task automatic model_step(input bit rdy, input bit clr,
                              input bit rv, input ent_t re, input bit lv, input ent_t le);
        bit take_rs;
        ent_t e;
        if (!rdy) return;
        if (clr) begin
            mq_rs.delete();
            mq_lsb.delete();
            m_valid = 0;
            m_last  = 1;
            return;
        end
        if (rv && mq_rs.size()  < DEPTH) mq_rs.push_back(re);
        if (lv && mq_lsb.size() < DEPTH) mq_lsb.push_back(le);
        if (mq_rs.size() == 0 && mq_lsb.size() == 0) begin
            m_valid = 0;
            return;
        end
        if (mq_rs.size() > 0 && mq_lsb.size() > 0) take_rs = (m_last == 1);
        else                                       take_rs = (mq_rs.size() > 0);
        if (take_rs) e = mq_rs.pop_front();
        else         e = mq_lsb.pop_front();
        m_valid = 1;
        m_id    = e.id;
        m_val   = e.val;
        m_src   = !take_rs;
        m_last  = !take_rs;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        clear  = 1'b0;
        drive(0, '0, '0, 0, '0, '0);
        #12;
        check_all("reset_state", 0, '0, '0, 0, 1, 1);
        #1;
        rst_in = 1'b0;

        // Single RS result on an idle bus: one-edge latency, one-cycle pulse.
        vecs.push_back(mk(0,1,0, 1,4'd3,32'h11,   0,4'd0,32'h0,   1,4'd3,32'h11,  0,1,1));
        vecs.push_back(mk(0,1,0, 0,4'd0,32'h0,    0,4'd0,32'h0,   0,4'd3,32'h11,  0,1,1));
        // Conflict out of reset: RS first, then LSB; next conflict goes to RS.
        vecs.push_back(mk(1,1,0, 1,4'd1,32'hA,    1,4'd2,32'hB,   1,4'd1,32'hA,   0,1,1));
        vecs.push_back(mk(0,1,0, 0,4'd0,32'h0,    0,4'd0,32'h0,   1,4'd2,32'hB,   1,1,1));
        vecs.push_back(mk(0,1,0, 1,4'd4,32'hC,    1,4'd5,32'hD,   1,4'd4,32'hC,   0,1,1));
        vecs.push_back(mk(0,1,0, 0,4'd0,32'h0,    0,4'd0,32'h0,   1,4'd5,32'hD,   1,1,1));
        vecs.push_back(mk(0,1,0, 0,4'd0,32'h0,    0,4'd0,32'h0,   0,4'd5,32'hD,   1,1,1));
        // Both producers streaming: alternation, full FIFOs, a dropped result.
        vecs.push_back(mk(1,1,0, 1,4'd1,32'h101,  1,4'd8,32'h208,  1,4'd1,32'h101, 0,1,1));
        vecs.push_back(mk(0,1,0, 1,4'd2,32'h102,  1,4'd9,32'h209,  1,4'd8,32'h208, 1,1,1));
        vecs.push_back(mk(0,1,0, 1,4'd3,32'h103,  1,4'd10,32'h20A, 1,4'd2,32'h102, 0,1,0));
        vecs.push_back(mk(0,1,0, 1,4'd4,32'h104,  1,4'd15,32'hDEAD,1,4'd9,32'h209, 1,0,1));
        vecs.push_back(mk(0,1,0, 0,4'd0,32'h0,    1,4'd11,32'h20B, 1,4'd3,32'h103, 0,1,0));
        vecs.push_back(mk(0,1,0, 1,4'd5,32'h105,  0,4'd0,32'h0,    1,4'd10,32'h20A,1,0,1));
        vecs.push_back(mk(0,1,0, 0,4'd0,32'h0,    0,4'd0,32'h0,    1,4'd4,32'h104, 0,1,1));
        vecs.push_back(mk(0,1,0, 0,4'd0,32'h0,    0,4'd0,32'h0,    1,4'd11,32'h20B,1,1,1));
        vecs.push_back(mk(0,1,0, 0,4'd0,32'h0,    0,4'd0,32'h0,    1,4'd5,32'h105, 0,1,1));
        vecs.push_back(mk(0,1,0, 0,4'd0,32'h0,    0,4'd0,32'h0,    0,4'd5,32'h105, 0,1,1));
        // Clear with buffered entries and an RS result in the clear cycle.
        vecs.push_back(mk(1,1,0, 1,4'd1,32'h301,  1,4'd8,32'h408,  1,4'd1,32'h301, 0,1,1));
        vecs.push_back(mk(0,1,0, 1,4'd2,32'h302,  1,4'd9,32'h409,  1,4'd8,32'h408, 1,1,1));
        vecs.push_back(mk(0,1,0, 1,4'd3,32'h303,  1,4'd10,32'h40A, 1,4'd2,32'h302, 0,1,0));
        vecs.push_back(mk(0,1,1, 1,4'd5,32'h305,  0,4'd0,32'h0,    0,4'd2,32'h302, 0,1,1));
        vecs.push_back(mk(0,1,0, 0,4'd0,32'h0,    0,4'd0,32'h0,    0,4'd2,32'h302, 0,1,1));
        vecs.push_back(mk(0,1,0, 1,4'd6,32'h306,  1,4'd12,32'h40C, 1,4'd6,32'h306, 0,1,1));
        vecs.push_back(mk(0,1,0, 0,4'd0,32'h0,    0,4'd0,32'h0,    1,4'd12,32'h40C,1,1,1));
        vecs.push_back(mk(0,1,0, 0,4'd0,32'h0,    0,4'd0,32'h0,    0,4'd12,32'h40C,1,1,1));
        // rdy_in low freezes everything, even over clear, then draining resumes.
        vecs.push_back(mk(1,1,0, 1,4'd1,32'h501,  1,4'd8,32'h608,  1,4'd1,32'h501, 0,1,1));
        vecs.push_back(mk(0,1,0, 1,4'd2,32'h502,  1,4'd9,32'h609,  1,4'd8,32'h608, 1,1,1));
        vecs.push_back(mk(0,0,0, 1,4'd7,32'h5FF,  1,4'd14,32'h6FF, 1,4'd8,32'h608, 1,1,1));
        vecs.push_back(mk(0,0,1, 1,4'd7,32'h5FF,  1,4'd14,32'h6FF, 1,4'd8,32'h608, 1,1,1));
        vecs.push_back(mk(0,0,0, 1,4'd7,32'h5FF,  1,4'd14,32'h6FF, 1,4'd8,32'h608, 1,1,1));
        vecs.push_back(mk(0,1,0, 0,4'd0,32'h0,    0,4'd0,32'h0,    1,4'd2,32'h502, 0,1,1));
        vecs.push_back(mk(0,1,0, 0,4'd0,32'h0,    0,4'd0,32'h0,    1,4'd9,32'h609, 1,1,1));
        vecs.push_back(mk(0,1,0, 0,4'd0,32'h0,    0,4'd0,32'h0,    0,4'd9,32'h609, 1,1,1));

        foreach (vecs[i]) apply(i, vecs[i]);

        // Asynchronous reset between edges while a result is buffered.
        rdy_in = 1'b1;
        clear  = 1'b0;
        drive(1, 4'd1, 32'h701, 1, 4'd8, 32'h708);
        @(posedge clk_in);
        #1;
        check_all("arst_pre", 1, 4'd1, 32'h701, 0, 1, 1);
        drive(0, '0, '0, 0, '0, '0);
        #2;
        rst_in = 1'b1;
        #1;
        check_all("arst_immediate", 0, '0, '0, 0, 1, 1);
        #1;
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        check_all("arst_discarded", 0, '0, '0, 0, 1, 1);
        drive(1, 4'd2, 32'h702, 1, 4'd9, 32'h709);
        @(posedge clk_in);
        #1;
        check_all("arst_conflict_rs", 1, 4'd2, 32'h702, 0, 1, 1);
        drive(0, '0, '0, 0, '0, '0);
        @(posedge clk_in);
        #1;
        check_all("arst_conflict_lsb", 1, 4'd9, 32'h709, 1, 1, 1);

        // Randomized traffic against the queue model.
        pulse_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit   r_rdy, r_clr, r_rv, r_lv;
            ent_t re, le;
            r_rdy = ($urandom_range(0, 9) != 0);
            r_clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) r_rv = 1'($urandom_range(0, 1));
            else r_rv = (mq_rs.size() < DEPTH) && ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) r_lv = 1'($urandom_range(0, 1));
            else r_lv = (mq_lsb.size() < DEPTH) && ($urandom_range(0, 9) < 7);
            re.id  = RW'($urandom_range(0, 15));
            re.val = $urandom();
            le.id  = RW'($urandom_range(0, 15));
            le.val = $urandom();
            rdy_in = r_rdy;
            clear  = r_clr;
            drive(r_rv, re.id, re.val, r_lv, le.id, le.val);
            model_step(r_rdy, r_clr, r_rv, re, r_lv, le);
            @(posedge clk_in);
            #1;
            check_all($sformatf("rand%0d", c), m_valid, m_id, m_val, m_src,
                      mq_rs.size() < DEPTH, mq_lsb.size() < DEPTH);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
